// File: rtl/clocks_ce_pkg.sv
// Shared types and helpers for the clock-enable generator.
package clocks_ce_pkg;

  typedef enum logic [1:0] {WAIT_LOCK, ALIGN, RUN} state_t;

  function automatic int ch_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Counter preload that makes a channel strobe 'phase' cycles after alignment.
  function automatic int unsigned align_value(input int unsigned n, input int unsigned phase);
    int unsigned p;
    if (n == 0) return 0;
    p = (phase >= n) ? 0 : phase;
    return (p == 0) ? 0 : n - p;
  endfunction

endpackage

// File: rtl/clocks_ce_div.sv
// One divider channel: shadowed config, wrap-aligned commit, strobe and square-wave decode.
module clocks_ce_div
  import clocks_ce_pkg::*;
#(
  parameter int DIV_W       = 8,
  parameter int DEFAULT_DIV = 5
) (
  input  logic             refclk,
  input  logic             rst,
  input  state_t           state,
  input  logic             wr,
  input  logic [DIV_W-1:0] wr_div,
  input  logic [DIV_W-1:0] wr_phase,
  input  logic             sync_all,
  output logic             ce,
  output logic             div_wave
);

  logic [DIV_W-1:0] n, ph, shd_n, shd_ph, cnt;
  logic [DIV_W-1:0] eff_n, eff_ph, sel_n, sel_ph;
  logic             pend, eff_pend, wrap, commit;
  logic [DIV_W:0]   half;

  always_comb begin
    eff_n    = wr ? wr_div : shd_n;
    eff_ph   = wr ? wr_phase : shd_ph;
    eff_pend = wr || pend;
    wrap     = (n != '0) && (cnt >= n - DIV_W'(1));
    // A write landing on the wrap cycle takes effect at that wrap.
    commit   = eff_pend && ((state != RUN) || (n == '0) || wrap || sync_all);
    sel_n    = commit ? eff_n : n;
    sel_ph   = commit ? eff_ph : ph;
    half     = ({1'b0, n} + (DIV_W+1)'(1)) >> 1;
  end

  always_ff @(posedge refclk) begin
    if (rst) begin
      n      <= DIV_W'(DEFAULT_DIV);
      ph     <= '0;
      shd_n  <= '0;
      shd_ph <= '0;
      pend   <= 1'b0;
      cnt    <= '0;
    end else begin
      if (wr) begin
        shd_n  <= wr_div;
        shd_ph <= wr_phase;
      end
      if (commit) begin
        n    <= eff_n;
        ph   <= eff_ph;
        pend <= 1'b0;
      end else if (wr) begin
        pend <= 1'b1;
      end
      if (state == ALIGN)
        cnt <= DIV_W'(align_value(32'(sel_n), 32'(sel_ph)));
      else if (commit)
        cnt <= '0;
      else if (state == RUN)
        cnt <= (wrap || n == '0) ? '0 : cnt + DIV_W'(1);
    end
  end

  assign ce       = (state == RUN) && (n != '0) && (cnt == '0);
  assign div_wave = (state == RUN) && (n != '0) && ({1'b0, cnt} < half);

endmodule

// File: rtl/clocks_ce_gen.sv
// Clock-enable generator top: lock synchroniser/debounce, sequencing FSM, config decode.
//   state     | meaning
//   WAIT_LOCK | counters frozen, outputs low, counting synchronised lock cycles
//   ALIGN     | single cycle, every channel preloads its phase offset
//   RUN       | channels divide, strobes and square waves active
module clocks_ce_gen
  import clocks_ce_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int DIV_W       = 8,
  parameter int DEFAULT_DIV = 5,
  parameter int LOCK_DLY    = 16,
  localparam int CH_W       = ch_width(NUM_CH)
) (
  input  logic              refclk,
  input  logic              rst,
  input  logic              pll_locked,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [DIV_W-1:0]  cfg_div,
  input  logic [DIV_W-1:0]  cfg_phase,
  input  logic              cfg_sync,
  output logic [NUM_CH-1:0] ce_out,
  output logic [NUM_CH-1:0] div_out,
  output logic              locked
);

  localparam int LC_W = $clog2(LOCK_DLY + 1);

  state_t            state;
  logic [1:0]        sync_q;
  logic              lock_s, accept, sync_all;
  logic [LC_W-1:0]   lock_cnt;
  logic [NUM_CH-1:0] wr;

  assign lock_s   = sync_q[1];
  assign accept   = cfg_valid && cfg_ready;
  assign sync_all = accept && cfg_sync && (state == RUN);

  always_comb begin
    wr = '0;
    for (int i = 0; i < NUM_CH; i++) wr[i] = accept && (cfg_ch == CH_W'(i));
  end

  always_ff @(posedge refclk) begin
    if (rst) begin
      sync_q    <= '0;
      lock_cnt  <= '0;
      state     <= WAIT_LOCK;
      locked    <= 1'b0;
      cfg_ready <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], pll_locked};
      if (!lock_s) begin
        state     <= WAIT_LOCK;
        lock_cnt  <= '0;
        locked    <= 1'b0;
        cfg_ready <= 1'b1;
      end else begin
        case (state)
          WAIT_LOCK: begin
            if (lock_cnt == LC_W'(LOCK_DLY - 1)) begin
              state     <= ALIGN;
              locked    <= 1'b1;
              cfg_ready <= 1'b0;
            end else begin
              lock_cnt <= lock_cnt + LC_W'(1);
            end
          end
          ALIGN: begin
            state     <= RUN;
            cfg_ready <= 1'b1;
          end
          RUN: begin
            if (sync_all) begin
              state     <= ALIGN;
              cfg_ready <= 1'b0;
            end
          end
          default: begin
            state     <= WAIT_LOCK;
            lock_cnt  <= '0;
            locked    <= 1'b0;
            cfg_ready <= 1'b1;
          end
        endcase
      end
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    clocks_ce_div #(
      .DIV_W       (DIV_W),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_ch (
      .refclk   (refclk),
      .rst      (rst),
      .state    (state),
      .wr       (wr[i]),
      .wr_div   (cfg_div),
      .wr_phase (cfg_phase),
      .sync_all (sync_all),
      .ce       (ce_out[i]),
      .div_wave (div_out[i])
    );
  end

endmodule
